matrix_multiplication: RTL and testbench
========================================

MATRIX_MULTIPLICATION -- requirements
Module: matrix_multiplication

Interface
REQ-001 Parameter: MEM_SIZE, default 4, maximum matrix dimension (rows and columns); MEM_SIZE >= 1.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: enable  input  1  start request; level-sensitive.
REQ-005 Port: operation_reg_port  input  192  six 32-bit words; word k occupies bits [32k+31:32k].
REQ-006 Port: matrixA_in_port  input  32*MEM_SIZE*MEM_SIZE  A[i][j] at bits [((i*MEM_SIZE)+j)*32 +: 32]; i is the row, j the column.
REQ-007 Port: matrixB_in_port  input  32*MEM_SIZE*MEM_SIZE  B[i][j], same packing as A.
REQ-008 Port: matrixC_out_port  output  32*MEM_SIZE*MEM_SIZE  registered result C[i][j], same packing.
REQ-009 Port: done  output  1  high when idle or finished; low while computing.

Function
REQ-010 Operation words used: word1 = wA (A columns), word2 = hA (A rows), word3 = wB (B columns), word4 = hB (B rows); words 0 and 5 are ignored.
REQ-011 States: IDLE (done=1), CALC (done=0), FIN (done=1).
REQ-012 IDLE with enable=1 at an edge: latch dimensions, clear all C entries to 0, clear accumulator, set i=j=k=0, drop done at that same edge, enter CALC.
REQ-013 CALC, each cycle: acc_next = acc + A[i][k]*B[k][j]; k advances; when k==wA-1, C[i][j] <= acc_next, acc <= 0, k <= 0, advance j, then i (row-major).
REQ-014 The edge that writes the final C[hA-1][wB-1] enters FIN and raises done; latency from the start edge to done high is exactly hA*wB*wA cycles.
REQ-015 FIN: stay while enable=1 (no restart while enable is held high); go to IDLE on the first edge with enable=0; done stays 1 throughout.
REQ-016 enable deasserting during CALC is ignored; the computation runs to completion.
REQ-017 Arithmetic: 32x32 product and 32-bit accumulator truncated to the low 32 bits (mod 2^32; identical for signed and unsigned operands).
REQ-018 C entries outside rows 0..hA-1 or columns 0..wB-1 are 0 after a run.
REQ-019 A and B are read live during CALC; the caller holds them stable from start until done.
REQ-020 C holds its value in FIN and IDLE until the next start or reset.
REQ-021 Dimension words use the full 32-bit value; a zero dimension yields no MAC cycles, C remains all 0, and done rises one cycle after the start edge.

Reset
REQ-022 reset=1 at an edge forces IDLE, done=1, all C entries=0, accumulator and indices=0; this applies in any state, including mid-CALC.
REQ-023 reset has priority over enable.

Configuration
REQ-024 Macro MATMUL_DIM_CHECK_EN defined: the run is invalid if any dimension is 0 or > MEM_SIZE, or if wA != hB.
REQ-025 For an invalid run: C stays all 0 and done rises one cycle after the start edge.
REQ-026 Macro MATMUL_DIM_CHECK_EN not defined: each dimension is clamped to min(value, MEM_SIZE), hB is ignored, and the inner length is the clamped wA.

Verification
REQ-027 A=[[1,2],[3,4]], B=I2, dimensions 2/2/2/2, pulse enable -> C=[[1,2],[3,4]]; done low for exactly 8 cycles.
REQ-028 A 2x3=[[1,2,3],[4,5,6]], B 3x2=[[7,8],[9,10],[11,12]] -> C=[[58,64],[139,154]]; all other entries 0; latency 12 cycles.
REQ-029 A[0][0]=0xFFFFFFFF, B[0][0]=2, 1x1 -> C[0][0]=0xFFFFFFFE.
REQ-030 With MATMUL_DIM_CHECK_EN: wA=3, hB=2 -> C all 0; done high one cycle after start.
REQ-031 reset asserted mid-CALC -> next cycle done=1, C all 0; a new start then produces the correct result.
REQ-032 enable held high for 5 cycles after done rises -> no restart and C unchanged; after enable drops, a new enable pulse restarts the computation.

Source files
------------

// File: rtl/matrix_multiplication.sv
// ---------------------------------------------------------------------------
// matrix_multiplication
//
// Purpose:
//   Sequential matrix multiplier C = A x B using a single 32-bit
//   multiply-accumulate datapath. One product term is accumulated per
//   clock cycle, walking the result row-major (i outer, j middle, k inner).
//   All arithmetic is modulo 2^32, so signed and unsigned operands give
//   identical bit patterns.
//
// Parameters:
//   MEM_SIZE            maximum matrix dimension (rows and columns), >= 1
//
// Ports:
//   clk                 single clock, all logic on the rising edge
//   reset               synchronous, active-high reset (wins over enable)
//   enable              level-sensitive start request
//   operation_reg_port  six 32-bit words: word1 = wA (A columns),
//                       word2 = hA (A rows), word3 = wB (B columns),
//                       word4 = hB (B rows); words 0 and 5 are ignored
//   matrixA_in_port     A[i][j] at bits [((i*MEM_SIZE)+j)*32 +: 32]
//   matrixB_in_port     B[i][j], same packing as A
//   matrixC_out_port    registered result C[i][j], same packing as A
//   done                high when idle or finished, low while computing
//
// Build option:
//   MATMUL_DIM_CHECK_EN  when defined, a run whose dimensions are zero,
//                        larger than MEM_SIZE, or with wA != hB performs no
//                        MAC cycles and leaves C all zero. When undefined,
//                        each dimension is clamped to MEM_SIZE, hB is
//                        ignored and the inner length is the clamped wA.
//
// A and B are read live during the computation; the caller keeps them
// stable from the start edge until done rises.
// ---------------------------------------------------------------------------
module matrix_multiplication #(
    parameter int MEM_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [191:0]                     operation_reg_port,
    input  logic [32*MEM_SIZE*MEM_SIZE-1:0]  matrixA_in_port,
    input  logic [32*MEM_SIZE*MEM_SIZE-1:0]  matrixB_in_port,
    output logic [32*MEM_SIZE*MEM_SIZE-1:0]  matrixC_out_port,
    output logic                             done
);

    localparam int NUM_ELEM = MEM_SIZE * MEM_SIZE;
    // Dimension registers must hold the value MEM_SIZE itself.
    localparam int DIM_W    = $clog2(MEM_SIZE + 1);
    localparam int FLAT_W   = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    localparam logic [DIM_W-1:0]  DIM_ZERO  = DIM_W'(0);
    localparam logic [DIM_W-1:0]  DIM_ONE   = DIM_W'(1);
    localparam logic [DIM_W-1:0]  DIM_MAX   = DIM_W'(MEM_SIZE);
    localparam logic [FLAT_W-1:0] FLAT_ROW  = FLAT_W'(MEM_SIZE);
    localparam logic [31:0]       WORD_MAX  = 32'(MEM_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              done_r;

    logic [DIM_W-1:0]  wa_r;
    logic [DIM_W-1:0]  ha_r;
    logic [DIM_W-1:0]  wb_r;
    logic              empty_r;
    logic [DIM_W-1:0]  i_r;
    logic [DIM_W-1:0]  j_r;
    logic [DIM_W-1:0]  k_r;
    logic [31:0]       acc_r;
    logic [31:0]       c_r [NUM_ELEM];

    logic [31:0]       wa_word_s;
    logic [31:0]       ha_word_s;
    logic [31:0]       wb_word_s;
    logic [31:0]       hb_word_s;
    logic [DIM_W-1:0]  wa_dim_s;
    logic [DIM_W-1:0]  ha_dim_s;
    logic [DIM_W-1:0]  wb_dim_s;
    logic              start_empty_s;

    logic [31:0]       a_s [NUM_ELEM];
    logic [31:0]       b_s [NUM_ELEM];
    logic [FLAT_W-1:0] a_idx_s;
    logic [FLAT_W-1:0] b_idx_s;
    logic [FLAT_W-1:0] c_idx_s;
    logic [31:0]       prod_s;
    logic [31:0]       mac_s;
    logic              last_k_s;
    logic              last_j_s;
    logic              last_i_s;
    logic              unused_bits_s;

    // Saturate a full 32-bit dimension word to the supported maximum.
    function automatic logic [DIM_W-1:0] clamp_dim(input logic [31:0] value);
        logic [DIM_W-1:0] result;
        if (value > WORD_MAX) begin
            result = DIM_MAX;
        end else begin
            result = DIM_W'(value);
        end
        return result;
    endfunction

    assign wa_word_s = operation_reg_port[63:32];
    assign ha_word_s = operation_reg_port[95:64];
    assign wb_word_s = operation_reg_port[127:96];
    assign hb_word_s = operation_reg_port[159:128];

    assign wa_dim_s  = clamp_dim(wa_word_s);
    assign ha_dim_s  = clamp_dim(ha_word_s);
    assign wb_dim_s  = clamp_dim(wb_word_s);

`ifdef MATMUL_DIM_CHECK_EN
    assign unused_bits_s = ^{operation_reg_port[191:160], operation_reg_port[31:0]};
`else
    assign unused_bits_s = ^{operation_reg_port[191:128], operation_reg_port[31:0]};
`endif

    // Decide at the start edge whether the run has zero MAC cycles.
    always_comb begin
        start_empty_s = 1'b0;
`ifdef MATMUL_DIM_CHECK_EN
        if ((wa_word_s == 32'd0) || (ha_word_s == 32'd0) ||
            (wb_word_s == 32'd0) || (hb_word_s == 32'd0) ||
            (wa_word_s > WORD_MAX) || (ha_word_s > WORD_MAX) ||
            (wb_word_s > WORD_MAX) || (hb_word_s > WORD_MAX) ||
            (wa_word_s != hb_word_s)) begin
            start_empty_s = 1'b1;
        end else begin
            start_empty_s = 1'b0;
        end
`else
        if ((wa_dim_s == DIM_ZERO) || (ha_dim_s == DIM_ZERO) ||
            (wb_dim_s == DIM_ZERO)) begin
            start_empty_s = 1'b1;
        end else begin
            start_empty_s = 1'b0;
        end
`endif
    end

    // Unpack the flat operand buses and pack the result bus.
    for (genvar g = 0; g < NUM_ELEM; g++) begin : g_pack
        assign a_s[g] = matrixA_in_port[g*32 +: 32];
        assign b_s[g] = matrixB_in_port[g*32 +: 32];
        assign matrixC_out_port[g*32 +: 32] = c_r[g];
    end

    // Element addressing and the single MAC term for this cycle.
    always_comb begin
        a_idx_s  = (FLAT_W'(i_r) * FLAT_ROW) + FLAT_W'(k_r);
        b_idx_s  = (FLAT_W'(k_r) * FLAT_ROW) + FLAT_W'(j_r);
        c_idx_s  = (FLAT_W'(i_r) * FLAT_ROW) + FLAT_W'(j_r);
        prod_s   = a_s[a_idx_s] * b_s[b_idx_s];
        mac_s    = acc_r + prod_s;
        last_k_s = (k_r == (wa_r - DIM_ONE));
        last_j_s = (j_r == (wb_r - DIM_ONE));
        last_i_s = (i_r == (ha_r - DIM_ONE));
    end

    // Next-state logic for the IDLE / CALC / FIN sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Enable is ignored here: a started run always completes.
                if (empty_r || (last_k_s && last_j_s && last_i_s)) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_FIN: begin
                // Holding enable high must not retrigger a run.
                if (enable) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s != ST_CALC);
        end
    end

    assign done = done_r;

    // Dimension latch, index walk, accumulator and result storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wa_r    <= DIM_ZERO;
            ha_r    <= DIM_ZERO;
            wb_r    <= DIM_ZERO;
            empty_r <= 1'b0;
            i_r     <= DIM_ZERO;
            j_r     <= DIM_ZERO;
            k_r     <= DIM_ZERO;
            acc_r   <= 32'd0;
            for (int e = 0; e < NUM_ELEM; e++) begin
                c_r[e] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        wa_r    <= wa_dim_s;
                        ha_r    <= ha_dim_s;
                        wb_r    <= wb_dim_s;
                        empty_r <= start_empty_s;
                        i_r     <= DIM_ZERO;
                        j_r     <= DIM_ZERO;
                        k_r     <= DIM_ZERO;
                        acc_r   <= 32'd0;
                        for (int e = 0; e < NUM_ELEM; e++) begin
                            c_r[e] <= 32'd0;
                        end
                    end
                end
                ST_CALC: begin
                    if (!empty_r) begin
                        if (last_k_s) begin
                            // Dot product complete: store it and move row-major.
                            c_r[c_idx_s] <= mac_s;
                            acc_r        <= 32'd0;
                            k_r          <= DIM_ZERO;
                            if (last_j_s) begin
                                j_r <= DIM_ZERO;
                                i_r <= i_r + DIM_ONE;
                            end else begin
                                j_r <= j_r + DIM_ONE;
                            end
                        end else begin
                            acc_r <= mac_s;
                            k_r   <= k_r + DIM_ONE;
                        end
                    end
                end
                default: begin
                    // FIN and IDLE without a start hold every result.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_multiplication.sv
// ---------------------------------------------------------------------------
// tb_matrix_multiplication
//
// Self-checking bench for matrix_multiplication (MEM_SIZE = 4). A
// behavioural model computes each expected result matrix with plain nested
// loops and the expected busy time from the dimensions; a compare process
// checks done and (when stable) the whole C bus on every falling edge.
// Hand-computed literals pin the model on the directed cases.
// ---------------------------------------------------------------------------
module tb_matrix_multiplication;

    localparam int N  = 4;
    localparam int NE = N * N;
    localparam int VW = 32 * NE;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [191:0]   op;
    logic [VW-1:0]  a_v;
    logic [VW-1:0]  b_v;
    logic [VW-1:0]  c_v;
    logic           done;

    int             checks = 0;
    int             errors = 0;

    logic           chk_en = 1'b0;
    logic           exp_done;
    logic           c_valid;
    logic [VW-1:0]  exp_c_v;

    logic [31:0]    a_m   [NE];
    logic [31:0]    b_m   [NE];
    logic [31:0]    exp_m [NE];

    always #5 clk = ~clk;

    matrix_multiplication #(.MEM_SIZE(N)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .operation_reg_port (op),
        .matrixA_in_port    (a_v),
        .matrixB_in_port    (b_v),
        .matrixC_out_port   (c_v),
        .done               (done)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every cycle: done must match the model; C must match whenever it is stable.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done t=%0t actual=%b required=%b", $time, done, exp_done);
            end
            if (c_valid) begin
                checks++;
                if (c_v !== exp_c_v) begin
                    errors++;
                    $display("FAIL c_bus t=%0t actual=%h required=%h", $time, c_v, exp_c_v);
                end
            end
        end
    end

    // Reference: C = A x B over the effective dimensions, everything else 0.
    task automatic model(input logic [31:0] wa, input logic [31:0] ha,
                         input logic [31:0] wb, input logic [31:0] hb,
                         output int lat);
        int          we, he, be;
        bit          invalid;
        logic [31:0] s;
        we = (wa > N) ? N : int'(wa);
        he = (ha > N) ? N : int'(ha);
        be = (wb > N) ? N : int'(wb);
`ifdef MATMUL_DIM_CHECK_EN
        invalid = (wa == 0) || (ha == 0) || (wb == 0) || (hb == 0) ||
                  (wa > N) || (ha > N) || (wb > N) || (hb > N) || (wa != hb);
`else
        invalid = (we == 0) || (he == 0) || (be == 0) || (hb == 32'hDEAD_BEEF && 1'b0);
`endif
        for (int e = 0; e < NE; e++) exp_m[e] = 32'd0;
        if (invalid) begin
            lat = 1;
        end else begin
            lat = he * be * we;
            for (int i = 0; i < he; i++) begin
                for (int j = 0; j < be; j++) begin
                    s = 32'd0;
                    for (int k = 0; k < we; k++) s = s + a_m[i*N+k] * b_m[k*N+j];
                    exp_m[i*N+j] = s;
                end
            end
        end
    endtask

    task automatic fill_random();
        for (int e = 0; e < NE; e++) begin
            a_m[e] = $urandom;
            b_m[e] = $urandom;
        end
    endtask

    // One run: start, optional enable hold after done, optional mid-run reset.
    task automatic run(input logic [31:0] wa, input logic [31:0] ha,
                       input logic [31:0] wb, input logic [31:0] hb,
                       input bit hold, input int abort_after, output int lat);
        model(wa, ha, wb, hb, lat);
        @(negedge clk);
        for (int e = 0; e < NE; e++) begin
            a_v[e*32 +: 32] = a_m[e];
            b_v[e*32 +: 32] = b_m[e];
        end
        op = {32'($urandom), hb, wb, ha, wa, 32'($urandom)};
        enable = 1'b1;
        @(posedge clk);
        exp_done = 1'b0;
        c_valid  = 1'b0;
        if (!hold) begin
            @(negedge clk);
            enable = 1'b0;
        end
        if (abort_after > 0) begin
            repeat (abort_after - 1) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            exp_done = 1'b1;
            exp_c_v  = '0;
            c_valid  = 1'b1;
            @(negedge clk);
            reset  = 1'b0;
            enable = 1'b0;
            @(posedge clk);
        end else begin
            repeat (lat - 1) @(posedge clk);
            @(posedge clk);
            exp_done = 1'b1;
            for (int e = 0; e < NE; e++) exp_c_v[e*32 +: 32] = exp_m[e];
            c_valid = 1'b1;
            if (hold) repeat (5) @(posedge clk);
            @(negedge clk);
            enable = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] wa, ha, wb, hb;

        reset    = 1'b1;
        enable   = 1'b0;
        op       = '0;
        a_v      = '0;
        b_v      = '0;
        exp_done = 1'b1;
        c_valid  = 1'b1;
        exp_c_v  = '0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check32("reset_done", {31'd0, done}, 32'd1);
        check32("reset_c00", c_v[31:0], 32'd0);
        reset = 1'b0;

        // A=[[1,2],[3,4]], B=I2.
        fill_random();
        a_m[0] = 32'd1; a_m[1] = 32'd2; a_m[4] = 32'd3; a_m[5] = 32'd4;
        b_m[0] = 32'd1; b_m[1] = 32'd0; b_m[4] = 32'd0; b_m[5] = 32'd1;
        run(32'd2, 32'd2, 32'd2, 32'd2, 1'b0, 0, lat);
        check32("t27_lat", 32'(lat), 32'd8);
        check32("t27_model_c11", exp_m[5], 32'd4);
        check32("t27_c00", c_v[0*32 +: 32], 32'd1);
        check32("t27_c01", c_v[1*32 +: 32], 32'd2);
        check32("t27_c10", c_v[4*32 +: 32], 32'd3);
        check32("t27_c11", c_v[5*32 +: 32], 32'd4);
        check32("t27_c02", c_v[2*32 +: 32], 32'd0);

        // 2x3 by 3x2.
        fill_random();
        a_m[0] = 32'd1; a_m[1] = 32'd2;  a_m[2] = 32'd3;
        a_m[4] = 32'd4; a_m[5] = 32'd5;  a_m[6] = 32'd6;
        b_m[0] = 32'd7; b_m[1] = 32'd8;
        b_m[4] = 32'd9; b_m[5] = 32'd10;
        b_m[8] = 32'd11; b_m[9] = 32'd12;
        run(32'd3, 32'd2, 32'd2, 32'd3, 1'b0, 0, lat);
        check32("t28_lat", 32'(lat), 32'd12);
        check32("t28_model_c00", exp_m[0], 32'd58);
        check32("t28_c00", c_v[0*32 +: 32], 32'd58);
        check32("t28_c01", c_v[1*32 +: 32], 32'd64);
        check32("t28_c10", c_v[4*32 +: 32], 32'd139);
        check32("t28_c11", c_v[5*32 +: 32], 32'd154);
        check32("t28_c12", c_v[6*32 +: 32], 32'd0);

        // Wrap-around product.
        fill_random();
        a_m[0] = 32'hFFFF_FFFF;
        b_m[0] = 32'd2;
        run(32'd1, 32'd1, 32'd1, 32'd1, 1'b0, 0, lat);
        check32("t29_lat", 32'(lat), 32'd1);
        check32("t29_c00", c_v[31:0], 32'hFFFF_FFFE);

        // Inner-dimension mismatch wA=3, hB=2.
        fill_random();
        run(32'd3, 32'd2, 32'd2, 32'd2, 1'b0, 0, lat);
`ifdef MATMUL_DIM_CHECK_EN
        check32("t30_lat", 32'(lat), 32'd1);
        check32("t30_c00", c_v[31:0], 32'd0);
`else
        check32("t30_lat", 32'(lat), 32'd12);
`endif

        // Zero and oversized dimensions.
        fill_random();
        run(32'd0, 32'd2, 32'd2, 32'd0, 1'b0, 0, lat);
        check32("zero_lat", 32'(lat), 32'd1);
        check32("zero_c00", c_v[31:0], 32'd0);
        fill_random();
        run(32'hFFFF_FFFF, 32'd5, 32'd3, 32'hFFFF_FFFF, 1'b0, 0, lat);

        // Reset in mid-run, then a clean restart.
        fill_random();
        run(32'd4, 32'd4, 32'd4, 32'd4, 1'b0, 10, lat);
        fill_random();
        run(32'd4, 32'd4, 32'd4, 32'd4, 1'b0, 0, lat);
        check32("t31_lat", 32'(lat), 32'd64);

        // Enable held after done, then a fresh pulse.
        fill_random();
        run(32'd2, 32'd2, 32'd2, 32'd2, 1'b1, 0, lat);
        fill_random();
        run(32'd3, 32'd3, 32'd3, 32'd3, 1'b0, 0, lat);

        // Randomized dimensions and operands.
        for (int r = 0; r < 25; r++) begin
            fill_random();
            wa = 32'($urandom_range(0, 5));
            ha = 32'($urandom_range(0, 5));
            wb = 32'($urandom_range(0, 5));
            hb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : wa;
            run(wa, ha, wb, hb, bit'($urandom_range(0, 1)), 0, lat);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
